// File: rtl/adaptive_filter_pkg.sv
// Shared fixed-point formats, coefficients and the round/saturate helper for
// the adaptive filter datapath (differentiator and integrator stages).
package adaptive_filter_pkg;

    // Sample format: Q7.6 signed
    localparam int DATA_WIDTH         = 14;
    localparam int FRACTIONAL_LENGTH  = 6;

    // Antisymmetric order-9 differentiator: 5 coefficient pairs, 10 taps
    localparam int FIR_DIFF_COEFF_NUM = 5;
    localparam int FIR_DIFF_TAPS      = 2 * FIR_DIFF_COEFF_NUM;

    localparam int DIFF_COEFF_WL      = 14;
    localparam int DIFF_COEFF_FL      = 12;

    // Pre-adder: one extra integer bit makes x[a]-x[b] overflow-free
    localparam int OP_DIFF_WL         = DATA_WIDTH + 1;
    localparam int OP_DIFF_FL         = FRACTIONAL_LENGTH;

    // Full-precision product of pre-adder output and coefficient
    localparam int MULTYPLYERS_WL     = OP_DIFF_WL + DIFF_COEFF_WL;
    localparam int MULTYPLYERS_FL     = OP_DIFF_FL + DIFF_COEFF_FL;

    // Accumulator format; two guard bits keep the five-term sum from wrapping
    localparam int OP_SUMM_WL         = 20;
    localparam int OP_SUMM_FL         = 12;
    localparam int OP_SUMM_GUARD_WL   = OP_SUMM_WL + 2;

    typedef logic signed [DATA_WIDTH-1:0]       sample_t;
    typedef logic signed [DIFF_COEFF_WL-1:0]    coeff_t;
    typedef logic signed [OP_DIFF_WL-1:0]       diff_t;
    typedef logic signed [MULTYPLYERS_WL-1:0]   mult_t;
    typedef logic signed [OP_SUMM_GUARD_WL-1:0] acc_t;

    typedef struct packed {
        logic    sat;
        sample_t data;
    } rs_result_t;

    // Coefficients a0..a4 in Q2.12
    localparam coeff_t fir_diff_coeff_a0 = -14'sd64;
    localparam coeff_t fir_diff_coeff_a1 =  14'sd800;
    localparam coeff_t fir_diff_coeff_a2 = -14'sd1632;
    localparam coeff_t fir_diff_coeff_a3 =  14'sd1800;
    localparam coeff_t fir_diff_coeff_a4 =  14'sd2430;

    localparam int     RS_SHIFT = OP_SUMM_FL - FRACTIONAL_LENGTH;
    localparam acc_t   RS_HALF  = acc_t'(1) <<< (RS_SHIFT - 1);
    localparam acc_t   SAT_MAX  = acc_t'(2 ** (DATA_WIDTH - 1) - 1);
    localparam acc_t   SAT_MIN  = acc_t'(-(2 ** (DATA_WIDTH - 1)));

    function automatic coeff_t fir_diff_coeff(input int k);
        case (k)
            0:       return fir_diff_coeff_a0;
            1:       return fir_diff_coeff_a1;
            2:       return fir_diff_coeff_a2;
            3:       return fir_diff_coeff_a3;
            4:       return fir_diff_coeff_a4;
            default: return '0;
        endcase
    endfunction

    // Round half-up from OP_SUMM_FL to FRACTIONAL_LENGTH, then clamp to a sample
    function automatic rs_result_t round_sat(input acc_t v);
        acc_t       r;
        rs_result_t res;
        r = (v + RS_HALF) >>> RS_SHIFT;
        if (r > SAT_MAX) begin
            res.data = sample_t'(SAT_MAX);
            res.sat  = 1'b1;
        end else if (r < SAT_MIN) begin
            res.data = sample_t'(SAT_MIN);
            res.sat  = 1'b1;
        end else begin
            res.data = sample_t'(r);
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_diff_tap.sv
// One coefficient pair of the antisymmetric FIR: registered pre-adder
// (x_new - x_old) followed by a registered multiply aligned to OP_SUMM_FL.
module fir_diff_tap
    import adaptive_filter_pkg::*;
#(
    parameter coeff_t COEF = '0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  sample_t x_new,
    input  sample_t x_old,
    output acc_t    prod
);
    localparam int ALIGN_SHIFT = MULTYPLYERS_FL - OP_SUMM_FL;

    diff_t diff_p0;
    mult_t prod_full;
    acc_t  prod_p1;

    assign prod_full = mult_t'(diff_p0) * mult_t'(COEF);
    assign prod      = prod_p1;

    // Stage 0: pre-add the mirrored sample pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            diff_p0 <= '0;
        else if (en)
            diff_p0 <= diff_t'(x_new) - diff_t'(x_old);
    end

    // Stage 1: full-precision product, truncated to the accumulator fraction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prod_p1 <= '0;
        else if (en)
            prod_p1 <= acc_t'(prod_full >>> ALIGN_SHIFT);
    end

endmodule

// File: rtl/fir_diff_stage.sv
// Order-9 antisymmetric FIR differentiator with valid/ready handshaking.
// Pipeline: pre-add -> multiply -> sum -> round/saturate (latency 4).
module fir_diff_stage
    import adaptive_filter_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat
);
    // The 10-entry delay line: entry 0 is the sample being accepted this
    // cycle, entries 1..9 are registered history. Feeding the taps from the
    // incoming sample keeps the pre-add in the same edge as the shift.
    sample_t    hist   [FIR_DIFF_TAPS-1];
    sample_t    window [FIR_DIFF_TAPS];
    acc_t       prod   [FIR_DIFF_COEFF_NUM];
    acc_t       sum_next;
    acc_t       sum_p2;
    rs_result_t rs;
    logic       adv;
    logic       accept;
    logic       vld_p0;
    logic       vld_p1;
    logic       vld_p2;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv && !clear;

    // Assemble the tap window x[n]..x[n-9]
    always_comb begin
        window[0] = in_data;
        for (int j = 1; j < FIR_DIFF_TAPS; j++)
            window[j] = hist[j-1];
    end

    // Delay line shifts only on an accepted sample; clear wins over accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int i = 0; i < FIR_DIFF_TAPS - 1; i++)
                hist[i] <= '0;
        end else if (accept) begin
            hist[0] <= in_data;
            for (int i = 1; i < FIR_DIFF_TAPS - 1; i++)
                hist[i] <= hist[i-1];
        end
    end

    for (genvar k = 0; k < FIR_DIFF_COEFF_NUM; k++) begin : g_tap
        fir_diff_tap #(
            .COEF  (fir_diff_coeff(k))
        ) u_tap (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .x_new (window[k]),
            .x_old (window[FIR_DIFF_TAPS-1-k]),
            .prod  (prod[k])
        );
    end

    // Five-term sum in the guarded accumulator width
    always_comb begin
        sum_next = '0;
        for (int k = 0; k < FIR_DIFF_COEFF_NUM; k++)
            sum_next = sum_next + prod[k];
    end

    // Stage 2: register the sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_p2 <= '0;
        else if (adv)
            sum_p2 <= sum_next;
    end

    assign rs = round_sat(sum_p2);

    // Stage 3: register the rounded/saturated result; held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (adv) begin
            out_data <= rs.data;
            out_sat  <= rs.sat;
        end
    end

    // Valid bits march with the data; empty stages travel as bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= accept;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
        end
    end

endmodule

// File: tb/tb_fir_diff_stage.sv
// Testbench for fir_diff_stage: scenario tasks against a floor-division
// reference of the differentiator equation.
module tb_fir_diff_stage;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic signed [13:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [13:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sat;

    always #5 clk = ~clk;

    fir_diff_stage dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state: hist[0] is the newest accepted sample
    int          hist [10];
    int          coef [5] = '{-64, 800, -1632, 1800, 2430};   // units of 2^-12
    logic [14:0] exp_q [$];
    logic [14:0] act_q [$];
    logic [14:0] ref_q [$];
    int          out_cyc_q [$];
    int          acc_cyc_q [$];

    logic        last_in_ready;
    logic        last_out_valid;
    logic [13:0] last_out_data;

    logic [13:0] imp_exp [10] = '{14'h3FFF, 14'h000D, 14'h3FE7, 14'h001C, 14'h0026,
                                  14'h3FDA, 14'h3FE4, 14'h001A, 14'h3FF4, 14'h0001};

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    // y = sum a_k (x[n-k] - x[n-9+k]); each product floored to 2^-12,
    // sum rounded half-up to 2^-6, then clamped to the 14-bit range
    function automatic logic [14:0] model_out();
        longint acc;
        longint p;
        longint y;
        logic   sat;
        logic [13:0] d;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            p   = longint'(hist[k] - hist[9-k]) * longint'(coef[k]);
            acc = acc + floor_div(p, 64);
        end
        y   = floor_div(acc + 32, 64);
        sat = 1'b0;
        if (y > 8191) begin
            y = 8191;
            sat = 1'b1;
        end else if (y < -8192) begin
            y = -8192;
            sat = 1'b1;
        end
        d = 14'(y);
        return {sat, d};
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 10; i++) hist[i] = 0;
        exp_q.delete();
    endtask

    task automatic clear_logs();
        act_q.delete();
        ref_q.delete();
        out_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    // Drive one cycle, observe handshakes at the falling edge, step the model
    task automatic drive_cycle(input logic v, input logic [13:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(negedge clk);
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_out_data  = out_data;
        if (out_valid && r) begin
            act_q.push_back({out_sat, out_data});
            out_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) ref_q.push_back(exp_q.pop_front());
            else                  ref_q.push_back(15'bx);
        end
        if (c) begin
            model_flush();
        end else if (v && in_ready) begin
            for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'($signed(d));
            exp_q.push_back(model_out());
            acc_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_test();
        drive_cycle(1'b0, 14'h0, 1'b1, 1'b1);
        clear_logs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 14'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        model_flush();
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 14'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data); else n_pass++;
        n_checks++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b want 0", out_sat); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_impulse();
        logic [14:0] a;
        int          bad_lat;
        start_test();
        drive_cycle(1'b1, 14'h0040, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 14'h0000, 1'b1, 1'b0);
        idle(8);
        n_checks++; if (act_q.size() != 10) $display("FAIL impulse_count: got %0d want 10", act_q.size()); else n_pass++;
        bad_lat = 0;
        for (int i = 0; i < 10; i++)
            if (i >= act_q.size() || i >= acc_cyc_q.size() || out_cyc_q[i] - acc_cyc_q[i] != 4) bad_lat++;
        n_checks++; if (bad_lat != 0) $display("FAIL impulse_latency: %0d outputs not at latency 4, want 0", bad_lat); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a = (i < act_q.size()) ? act_q[i] : 15'bx;
            n_checks++;
            if (a !== {1'b0, imp_exp[i]}) $display("FAIL impulse_y%0d: got %h want %h", i, a, {1'b0, imp_exp[i]});
            else n_pass++;
        end
    endtask

    task automatic test_dc_step();
        start_test();
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 14'h0040, 1'b1, 1'b0);
        idle(8);
        n_checks++; if (act_q.size() != 20) $display("FAIL dc_count: got %0d want 20", act_q.size()); else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== ref_q[i]) $display("FAIL dc_model_y%0d: got %h want %h", i, act_q[i], ref_q[i]);
            else n_pass++;
            if (i >= 9) begin
                n_checks++;
                if (act_q[i] !== 15'h0000) $display("FAIL dc_zero_y%0d: got %h want 0000", i, act_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        logic        pos;
        int          k;
        logic [14:0] want;
        for (int inv = 0; inv < 2; inv++) begin
            start_test();
            for (int j = 9; j >= 0; j--) begin
                if (j <= 4) begin k = j;     pos = (coef[k] > 0);  end
                else        begin k = 9 - j; pos = !(coef[k] > 0); end
                if (inv == 1) pos = !pos;
                drive_cycle(1'b1, pos ? 14'h1FFF : 14'h2000, 1'b1, 1'b0);
            end
            idle(8);
            want = (inv == 1) ? {1'b1, 14'h2000} : {1'b1, 14'h1FFF};
            n_checks++;
            if (act_q.size() != 10) $display("FAIL sat%0d_count: got %0d want 10", inv, act_q.size());
            else n_pass++;
            n_checks++;
            if (act_q.size() != 10 || act_q[9] !== want) $display("FAIL sat%0d_clamp: got %h want %h", inv, (act_q.size() == 10) ? act_q[9] : 15'bx, want);
            else n_pass++;
            for (int i = 0; i < act_q.size(); i++) begin
                n_checks++;
                if (act_q[i] !== ref_q[i]) $display("FAIL sat%0d_model_y%0d: got %h want %h", inv, i, act_q[i], ref_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          idx;
        logic        v;
        logic        r;
        logic [13:0] frozen;
        logic [14:0] a;
        start_test();
        idx = 0;
        frozen = '0;
        for (int t = 0; t < 40; t++) begin
            r = !(t >= 6 && t < 11);
            v = (idx < 10);
            drive_cycle(v, (idx == 0) ? 14'h0040 : 14'h0000, r, 1'b0);
            if (v && last_in_ready) idx++;
            if (t == 6) frozen = last_out_data;
            if (t >= 6 && t < 11) begin
                n_checks++;
                if (last_in_ready !== 1'b0) $display("FAIL bp_in_ready_t%0d: got %b want 0", t, last_in_ready);
                else n_pass++;
                n_checks++;
                if (last_out_valid !== 1'b1 || last_out_data !== frozen)
                    $display("FAIL bp_hold_t%0d: got valid %b data %h want valid 1 data %h", t, last_out_valid, last_out_data, frozen);
                else n_pass++;
            end
        end
        n_checks++; if (act_q.size() != 10) $display("FAIL bp_count: got %0d want 10", act_q.size()); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a = (i < act_q.size()) ? act_q[i] : 15'bx;
            n_checks++;
            if (a !== {1'b0, imp_exp[i]}) $display("FAIL bp_y%0d: got %h want %h", i, a, {1'b0, imp_exp[i]});
            else n_pass++;
        end
    endtask

    // Abort an impulse after 3 outputs with clear (use_rst=0) or rst (use_rst=1)
    task automatic test_abort(input int use_rst);
        int          idx;
        logic        v;
        logic [14:0] a;
        start_test();
        idx = 0;
        for (int t = 0; t < 30 && act_q.size() < 3; t++) begin
            v = (idx < 10);
            drive_cycle(v, (idx == 0) ? 14'h0040 : 14'h0000, 1'b1, 1'b0);
            if (v && last_in_ready) idx++;
        end
        n_checks++;
        if (act_q.size() != 3) $display("FAIL abort%0d_pre_count: got %0d want 3", use_rst, act_q.size());
        else n_pass++;
        if (use_rst == 0) begin
            drive_cycle(1'b0, 14'h0, 1'b0, 1'b1);
        end else begin
            in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            model_flush();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL abort_rst_state: got valid %b ready %b want valid 0 ready 1", out_valid, in_ready);
            else n_pass++;
            rst = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        idle(12);
        n_checks++;
        if (act_q.size() != 3) $display("FAIL abort%0d_no_more_valid: got %0d outputs want 3", use_rst, act_q.size());
        else n_pass++;
        clear_logs();
        drive_cycle(1'b1, 14'h0040, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 14'h0000, 1'b1, 1'b0);
        idle(8);
        for (int i = 0; i < 10; i++) begin
            a = (i < act_q.size()) ? act_q[i] : 15'bx;
            n_checks++;
            if (a !== {1'b0, imp_exp[i]}) $display("FAIL abort%0d_y%0d: got %h want %h", use_rst, i, a, {1'b0, imp_exp[i]});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int          acc;
        logic        v;
        logic        r;
        logic [13:0] d;
        start_test();
        acc = 0;
        for (int t = 0; t < 60000 && acc < 10000; t++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       d = 14'h1FFF;
                1:       d = 14'h2000;
                2:       d = 14'(($urandom_range(0, 255)) - 128);
                default: d = 14'($urandom());
            endcase
            drive_cycle(v, d, r, 1'b0);
            if (v && last_in_ready) acc++;
        end
        idle(10);
        n_checks++; if (acc != 10000) $display("FAIL rand_accept_count: got %0d want 10000", acc); else n_pass++;
        n_checks++; if (act_q.size() != 10000) $display("FAIL rand_out_count: got %0d want 10000", act_q.size()); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL rand_lost: got %0d pending want 0", exp_q.size()); else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== ref_q[i]) $display("FAIL rand_y%0d: got %h want %h", i, act_q[i], ref_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_step();
        test_saturation();
        test_backpressure();
        test_abort(0);
        test_abort(1);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/fir_diff_stage.md
FIR_DIFF_STAGE -- requirements
Module: fir_diff_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port clear, input, 1 bit: synchronous flush of delay line and pipeline valids.
REQ-004 SHALL have port in_data, input, DATA_WIDTH (14) bits: signed sample, FRACTIONAL_LENGTH (6) fraction bits.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: stage accepts a sample this cycle.
REQ-007 SHALL have port out_data, output, 14 bits: signed differentiator output, 6 fraction bits.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 SHALL have port out_sat, output, 1 bit: the current out_data was saturated.

Function
REQ-011 SHALL implement the order-9 antisymmetric FIR y[n] = sum over k=0..4 of a_k*(x[n-k] - x[n-9+k]), using fir_diff_coeff_a0..a4 at their package WL/FL.
REQ-012 SHALL accept a sample when in_valid and in_ready are both 1, and only then shift it into a 10-entry delay line.
REQ-013 SHALL compute each pre-adder difference at OP_DIFF_WL (15) bits, OP_DIFF_FL (6) bits, with no overflow possible.
REQ-014 SHALL compute each product at full precision, then align it to OP_SUMM_FL (12).
REQ-015 SHALL sum the five products in OP_SUMM_WL+2 (22) bits so the sum never wraps.
REQ-016 SHALL round the sum round-half-up to 6 fraction bits: add 2^-7, then truncate.
REQ-017 SHALL saturate the rounded value to 14 bits: positive clamp 14'h1FFF, negative clamp 14'h2000; out_sat is 1 in that case.
REQ-018 SHALL be a 4-stage pipeline (pre-add, multiply, sum, round/saturate), each stage with its own valid bit.
REQ-019 SHALL have latency 4: an accepted sample appears on out_data exactly 4 cycles later when out_ready stays 1.
REQ-020 SHALL use the advance condition adv = !out_valid | out_ready.
REQ-021 SHALL drive in_ready = adv.
REQ-022 SHALL, when adv is 1, advance all pipeline stages together, with empty stages propagating as bubbles.
REQ-023 SHALL, when adv is 0, freeze all stages and the delay line.
REQ-024 SHALL hold out_data, out_sat and out_valid stable while out_valid is 1 and out_ready is 0.
REQ-025 SHALL sustain throughput of one sample per cycle with in_valid and out_ready held at 1.
REQ-026 SHALL, on clear, zero the delay line and all valid bits on the next edge, and drop any accept in that cycle.
REQ-027 SHALL give clear priority over in_valid when both are 1.

Reset
REQ-028 SHALL, on rst, asynchronously zero the delay line and pipeline data registers, set out_data to 14'h0000, and set out_valid and out_sat to 0.
REQ-029 SHALL have in_ready equal to 1 during reset and after reset.
REQ-030 SHALL, on reset mid-stream, discard all in-flight samples; the first output after reset uses a zeroed history.

Structure
REQ-031 SHALL take DATA_WIDTH, FRACTIONAL_LENGTH, FIR_DIFF_COEFF_NUM, DIFF_COEFF_WL/FL, the coefficients, MULTYPLYERS_WL/FL, OP_SUMM_* and OP_DIFF_* from adaptive_filter_pkg only, with no local literals.
REQ-032 SHALL place the round/saturate function shared with the integrator stage, and the 22-bit guard width constant, in adaptive_filter_pkg.
REQ-033 SHALL instantiate sub-module fir_diff_tap, one per coefficient pair (pre-adder plus multiplier, 2 registers), 5 times.

Verification
REQ-034 SHALL cover impulse response: inputs 14'h0040 then nine 14'h0000 -> out_data 3FFF, 000D, 3FE7, 001C, 0026, 3FDA, 3FE4, 001A, 3FF4, 0001, all with out_sat 0.
REQ-035 SHALL cover a DC step: 14'h0040 held for 20 samples -> out_data is 14'h0000 from the 10th output on.
REQ-036 SHALL cover saturation: x[n-k] = +127.98 (1FFF) or -128 (2000) matched to sign(a_k), mirrored for taps 5..9 -> out_data 14'h1FFF with out_sat 1; the sign-inverted pattern -> 14'h2000 with out_sat 1.
REQ-037 SHALL cover backpressure: out_ready held 0 for 5 cycles mid-impulse -> in_ready 0, out_data frozen, and the sequence is identical to REQ-034 with no loss or duplication.
REQ-038 SHALL cover clear and reset: clear or rst asserted after 3 impulse outputs -> no further out_valid, and a new impulse reproduces REQ-034 exactly.
REQ-039 SHALL cover random valid/ready: 10^4 random samples with random in_valid and out_ready -> bit-exact match to a reference model of REQ-011..017.
